prog_clk_divider: RTL and testbench

- Runtime-programmable single-clock divider; successor to the fixed one-hot ring dividers feeding generated clocks.
- Divide ratio is set through a valid/ready config port and applied glitch-free, only at period boundaries.
- Enable stop/start completes the current period before parking the output low.
- Outputs a registered divided clock, a period tick and status; the divided clock drives downstream generated-clock domains.

---
 rtl/clkdiv_pkg.sv | 16 +
 rtl/prog_clk_divider_if.sv | 14 +
 rtl/clkdiv_cfg_slot.sv | 45 ++++
 rtl/prog_clk_divider.sv | 106 ++++++++++
 tb/tb_prog_clk_divider.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clkdiv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} clkdiv_state_e;

  // Length of the high phase: ceil(N/2), so odd ratios get the extra cycle high.
  function automatic int clkdiv_hi_len(input int n);
    return (n + 1) / 2;
  endfunction

  // A ratio is usable when it spans at least one high and one low cycle.
  function automatic logic clkdiv_legal(input int n, input int max_div);
    return (n >= 2) && (n <= max_div);
  endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Ratio configuration handshake between a programming agent and the divider.
interface prog_clk_divider_if #(
  parameter int MAX_DIV = 16
);
  localparam int CNT_W = $clog2(MAX_DIV + 1);

  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_div, input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clkdiv_cfg_slot.sv
// Single-entry pending-ratio slot: accepts legal ratios, flags illegal ones,
// and holds the accepted value until the divider applies it.
module clkdiv_cfg_slot
  import clkdiv_pkg::*;
#(
  parameter  int MAX_DIV = 16,
  localparam int CNT_W   = $clog2(MAX_DIV + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  prog_clk_divider_if.slave cfg,
  input  logic             apply,
  output logic             pending_vld,
  output logic [CNT_W-1:0] pending_div
);

  logic xfer;
  logic legal;

  assign xfer  = cfg.cfg_valid & cfg.cfg_ready;
  assign legal = clkdiv_legal(int'(cfg.cfg_div), MAX_DIV);

  // Capture legal ratios, pulse cfg_err for illegal ones, release on apply.
  // apply only fires while pending_vld=1, i.e. while cfg_ready=0, so it can
  // never coincide with a new transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_vld   <= 1'b0;
      pending_div   <= '0;
      cfg.cfg_ready <= 1'b1;
      cfg.cfg_err   <= 1'b0;
    end else begin
      cfg.cfg_err <= xfer & ~legal;
      if (xfer && legal) begin
        pending_vld   <= 1'b1;
        pending_div   <= cfg.cfg_div;
        cfg.cfg_ready <= 1'b0;
      end else if (apply) begin
        pending_vld   <= 1'b0;
        cfg.cfg_ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_clk_divider.sv
// Runtime-programmable clock divider with glitch-free ratio changes and
// drain-to-boundary stop. Optional one-hot phase output when
// CLKDIV_PHASE_OUT_EN is defined.
module prog_clk_divider
  import clkdiv_pkg::*;
#(
  parameter  int MAX_DIV   = 16,
  parameter  int RESET_DIV = 4,
  localparam int CNT_W     = $clog2(MAX_DIV + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  prog_clk_divider_if.slave cfg,
  output logic             div_clk,
  output logic             tick,
  output logic [CNT_W-1:0] active_div,
  output logic             running
`ifdef CLKDIV_PHASE_OUT_EN
  ,
  output logic [MAX_DIV-1:0] phase_out
`endif
);

  clkdiv_state_e    state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_n;
  logic [CNT_W-1:0] hi_n;
  logic             boundary;
  logic             apply;
  logic             pending_vld;
  logic [CNT_W-1:0] pending_div;

  clkdiv_cfg_slot #(.MAX_DIV(MAX_DIV)) u_slot (
    .clock       (clock),
    .reset_n     (reset_n),
    .cfg         (cfg),
    .apply       (apply),
    .pending_vld (pending_vld),
    .pending_div (pending_div)
  );

  assign boundary = (state != IDLE) && (cnt == active_div - CNT_W'(1));
  assign hi_n     = CNT_W'(clkdiv_hi_len(int'(div_n)));

  // Next-state: ratio swaps only at a boundary or while idle, so no phase is cut short.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = active_div;
    apply   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (pending_vld) begin
          apply = 1'b1;
          div_n = pending_div;
        end
        if (enable) state_n = RUN;
      end
      default: begin
        if (boundary) begin
          cnt_n = '0;
          if (pending_vld) begin
            apply = 1'b1;
            div_n = pending_div;
          end
          state_n = enable ? RUN : IDLE;
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          state_n = enable ? RUN : DRAIN;
        end
      end
    endcase
  end

  // State and outputs registered from next-state values; div_clk is a pure flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      active_div <= CNT_W'(RESET_DIV);
      div_clk    <= 1'b0;
      tick       <= 1'b0;
      running    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      active_div <= div_n;
      div_clk    <= (state_n != IDLE) && (cnt_n < hi_n);
      tick       <= (state_n != IDLE) && (cnt_n == div_n - CNT_W'(1));
      running    <= (state_n != IDLE);
    end
  end

`ifdef CLKDIV_PHASE_OUT_EN
  localparam logic [MAX_DIV-1:0] PH0 = MAX_DIV'(1);

  // One-hot phase of the current period; silent while idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) phase_out <= '0;
    else          phase_out <= (state_n != IDLE) ? (PH0 << cnt_n) : '0;
  end
`endif

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider (MAX_DIV=16, RESET_DIV=4).
module tb_prog_clk_divider;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       div_clk;
  logic       tick;
  logic [4:0] active_div;
  logic       running;
`ifdef CLKDIV_PHASE_OUT_EN
  logic [15:0] phase_out;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  prog_clk_divider_if #(.MAX_DIV(16)) cfg_if ();

  prog_clk_divider #(.MAX_DIV(16), .RESET_DIV(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .cfg        (cfg_if),
    .div_clk    (div_clk),
    .tick       (tick),
    .active_div (active_div),
    .running    (running)
`ifdef CLKDIV_PHASE_OUT_EN
    ,
    .phase_out  (phase_out)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one source cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    enable           = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    reset_n          = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    vec_cnt++; if (div_clk !== 1'b0) begin err_cnt++; $display("FAIL reset_div_clk: got %b want 0", div_clk); end
    vec_cnt++; if (tick !== 1'b0) begin err_cnt++; $display("FAIL reset_tick: got %b want 0", tick); end
    vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL reset_running: got %b want 0", running); end
    vec_cnt++; if (cfg_if.cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_if.cfg_ready); end
    vec_cnt++; if (cfg_if.cfg_err !== 1'b0) begin err_cnt++; $display("FAIL reset_cfg_err: got %b want 0", cfg_if.cfg_err); end
    vec_cnt++; if (active_div !== 5'd4) begin err_cnt++; $display("FAIL reset_active_div: got %0d want 4", active_div); end
    // Idle with enable low: stays parked
    step();
    vec_cnt++; if (div_clk !== 1'b0) begin err_cnt++; $display("FAIL idle_div_clk: got %b want 0", div_clk); end
  endtask

  task automatic test_run_div4();
    pulse_reset();
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int c;
      step();
      c = i % 4;
      vec_cnt++; if (div_clk !== (c < 2)) begin err_cnt++; $display("FAIL run4_div_clk cyc %0d: got %b want %b", i, div_clk, (c < 2)); end
      vec_cnt++; if (tick !== (c == 3)) begin err_cnt++; $display("FAIL run4_tick cyc %0d: got %b want %b", i, tick, (c == 3)); end
      vec_cnt++; if (running !== 1'b1) begin err_cnt++; $display("FAIL run4_running cyc %0d: got %b want 1", i, running); end
`ifdef CLKDIV_PHASE_OUT_EN
      begin
        logic [15:0] exp_ph;
        exp_ph = 16'd1 << c;
        vec_cnt++; if (phase_out !== exp_ph) begin err_cnt++; $display("FAIL run4_phase cyc %0d: got %h want %h", i, phase_out, exp_ph); end
      end
`endif
    end
  endtask

  task automatic test_cfg_apply();
    pulse_reset();
    enable = 1'b1;
    step();  // cnt 0
    step();  // cnt 1
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 5'd5;
    step();  // cnt 2, ratio now pending
    cfg_if.cfg_valid = 1'b0;
    vec_cnt++; if (cfg_if.cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL apply_ready_low: got %b want 0", cfg_if.cfg_ready); end
    vec_cnt++; if (active_div !== 5'd4) begin err_cnt++; $display("FAIL apply_old_div: got %0d want 4", active_div); end
    vec_cnt++; if (div_clk !== 1'b0) begin err_cnt++; $display("FAIL apply_cnt2_div_clk: got %b want 0", div_clk); end
    step();  // cnt 3, boundary of old period
    vec_cnt++; if (tick !== 1'b1) begin err_cnt++; $display("FAIL apply_old_tick: got %b want 1", tick); end
    vec_cnt++; if (active_div !== 5'd4) begin err_cnt++; $display("FAIL apply_div_at_bnd: got %0d want 4", active_div); end
    vec_cnt++; if (cfg_if.cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL apply_ready_bnd: got %b want 0", cfg_if.cfg_ready); end
    for (int i = 0; i < 10; i++) begin
      int c;
      step();
      c = i % 5;
      vec_cnt++; if (div_clk !== (c < 3)) begin err_cnt++; $display("FAIL n5_div_clk cyc %0d: got %b want %b", i, div_clk, (c < 3)); end
      vec_cnt++; if (tick !== (c == 4)) begin err_cnt++; $display("FAIL n5_tick cyc %0d: got %b want %b", i, tick, (c == 4)); end
      vec_cnt++; if (active_div !== 5'd5) begin err_cnt++; $display("FAIL n5_active cyc %0d: got %0d want 5", i, active_div); end
      if (i == 0) begin
        vec_cnt++; if (cfg_if.cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL apply_ready_back: got %b want 1", cfg_if.cfg_ready); end
      end
    end
  endtask

  task automatic test_illegal();
    logic [4:0] bad [2];
    bad[0] = 5'd1;
    bad[1] = 5'd17;
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_div   = bad[k];
      step();
      cfg_if.cfg_valid = 1'b0;
      vec_cnt++; if (cfg_if.cfg_err !== 1'b1) begin err_cnt++; $display("FAIL illegal_err val %0d: got %b want 1", bad[k], cfg_if.cfg_err); end
      vec_cnt++; if (cfg_if.cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL illegal_ready val %0d: got %b want 1", bad[k], cfg_if.cfg_ready); end
      step();
      vec_cnt++; if (cfg_if.cfg_err !== 1'b0) begin err_cnt++; $display("FAIL illegal_err_pulse val %0d: got %b want 0", bad[k], cfg_if.cfg_err); end
      vec_cnt++; if (active_div !== 5'd4) begin err_cnt++; $display("FAIL illegal_active val %0d: got %0d want 4", bad[k], active_div); end
    end
    // Upper legal limit, applied next cycle while idle
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 5'd16;
    step();
    cfg_if.cfg_valid = 1'b0;
    vec_cnt++; if (cfg_if.cfg_err !== 1'b0) begin err_cnt++; $display("FAIL legal16_err: got %b want 0", cfg_if.cfg_err); end
    vec_cnt++; if (cfg_if.cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL legal16_ready: got %b want 0", cfg_if.cfg_ready); end
    step();
    vec_cnt++; if (active_div !== 5'd16) begin err_cnt++; $display("FAIL legal16_active: got %0d want 16", active_div); end
    step();
    vec_cnt++; if (cfg_if.cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL legal16_ready_back: got %b want 1", cfg_if.cfg_ready); end
    // Lower legal limit, then run it: 1 high, 1 low
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 5'd2;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    vec_cnt++; if (active_div !== 5'd2) begin err_cnt++; $display("FAIL legal2_active: got %0d want 2", active_div); end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vec_cnt++; if (div_clk !== (i % 2 == 0)) begin err_cnt++; $display("FAIL n2_div_clk cyc %0d: got %b want %b", i, div_clk, (i % 2 == 0)); end
      vec_cnt++; if (tick !== (i % 2 == 1)) begin err_cnt++; $display("FAIL n2_tick cyc %0d: got %b want %b", i, tick, (i % 2 == 1)); end
    end
  endtask

  task automatic test_drain();
    logic exp_d [4];
    pulse_reset();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 5'd6;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    vec_cnt++; if (active_div !== 5'd6) begin err_cnt++; $display("FAIL drain_setup_active: got %0d want 6", active_div); end
    enable = 1'b1;
    step();  // cnt 0
    step();  // cnt 1
    enable = 1'b0;
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b0; exp_d[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin  // cnt 2..5 while draining
      step();
      vec_cnt++; if (div_clk !== exp_d[i]) begin err_cnt++; $display("FAIL drain_div_clk cnt %0d: got %b want %b", i + 2, div_clk, exp_d[i]); end
      vec_cnt++; if (tick !== (i == 3)) begin err_cnt++; $display("FAIL drain_tick cnt %0d: got %b want %b", i + 2, tick, (i == 3)); end
      vec_cnt++; if (running !== 1'b1) begin err_cnt++; $display("FAIL drain_running cnt %0d: got %b want 1", i + 2, running); end
    end
    step();
    vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL drain_idle_running: got %b want 0", running); end
    vec_cnt++; if (div_clk !== 1'b0) begin err_cnt++; $display("FAIL drain_idle_div_clk: got %b want 0", div_clk); end
    vec_cnt++; if (tick !== 1'b0) begin err_cnt++; $display("FAIL drain_idle_tick: got %b want 0", tick); end
    // Second run: drop enable, re-assert during drain at cnt 4
    enable = 1'b1;
    step();  // cnt 0
    step();  // cnt 1
    enable = 1'b0;
    step();  // cnt 2
    step();  // cnt 3
    step();  // cnt 4
    enable = 1'b1;
    step();  // cnt 5
    vec_cnt++; if (tick !== 1'b1) begin err_cnt++; $display("FAIL rearm_tick: got %b want 1", tick); end
    for (int i = 0; i < 6; i++) begin
      step();
      vec_cnt++; if (div_clk !== (i < 3)) begin err_cnt++; $display("FAIL rearm_div_clk cnt %0d: got %b want %b", i, div_clk, (i < 3)); end
      vec_cnt++; if (running !== 1'b1) begin err_cnt++; $display("FAIL rearm_running cnt %0d: got %b want 1", i, running); end
    end
  endtask

  task automatic test_coincident();
    pulse_reset();
    enable = 1'b1;
    step();  // cnt 0
    step();  // cnt 1
    step();  // cnt 2
    step();  // cnt 3, tick cycle
    vec_cnt++; if (tick !== 1'b1) begin err_cnt++; $display("FAIL coin_tick: got %b want 1", tick); end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 5'd6;
    step();  // cnt 0, old ratio still in force
    cfg_if.cfg_valid = 1'b0;
    vec_cnt++; if (active_div !== 5'd4) begin err_cnt++; $display("FAIL coin_active_old: got %0d want 4", active_div); end
    vec_cnt++; if (cfg_if.cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL coin_ready: got %b want 0", cfg_if.cfg_ready); end
    for (int i = 1; i < 4; i++) begin
      step();
      vec_cnt++; if (div_clk !== (i < 2)) begin err_cnt++; $display("FAIL coin_old_div_clk cnt %0d: got %b want %b", i, div_clk, (i < 2)); end
      vec_cnt++; if (tick !== (i == 3)) begin err_cnt++; $display("FAIL coin_old_tick cnt %0d: got %b want %b", i, tick, (i == 3)); end
    end
    for (int i = 0; i < 6; i++) begin
      step();
      vec_cnt++; if (active_div !== 5'd6) begin err_cnt++; $display("FAIL coin_active_new cnt %0d: got %0d want 6", i, active_div); end
      vec_cnt++; if (div_clk !== (i < 3)) begin err_cnt++; $display("FAIL coin_new_div_clk cnt %0d: got %b want %b", i, div_clk, (i < 3)); end
      vec_cnt++; if (tick !== (i == 5)) begin err_cnt++; $display("FAIL coin_new_tick cnt %0d: got %b want %b", i, tick, (i == 5)); end
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    enable = 1'b1;
    step();  // cnt 0
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 5'd7;
    step();  // cnt 1, high phase, ratio pending
    cfg_if.cfg_valid = 1'b0;
    vec_cnt++; if (div_clk !== 1'b1) begin err_cnt++; $display("FAIL mid_pre_div_clk: got %b want 1", div_clk); end
    #2;
    reset_n = 1'b0;
    #1;
    vec_cnt++; if (div_clk !== 1'b0) begin err_cnt++; $display("FAIL mid_async_div_clk: got %b want 0", div_clk); end
    vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL mid_async_running: got %b want 0", running); end
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    vec_cnt++; if (active_div !== 5'd4) begin err_cnt++; $display("FAIL mid_rel_active: got %0d want 4", active_div); end
    vec_cnt++; if (cfg_if.cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL mid_rel_ready: got %b want 1", cfg_if.cfg_ready); end
`ifdef CLKDIV_PHASE_OUT_EN
    vec_cnt++; if (phase_out !== 16'd0) begin err_cnt++; $display("FAIL mid_rel_phase: got %h want 0", phase_out); end
`endif
    // A surviving pending ratio would be applied in idle here
    step();
    step();
    vec_cnt++; if (active_div !== 5'd4) begin err_cnt++; $display("FAIL mid_lost_pending: got %0d want 4", active_div); end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vec_cnt++; if (div_clk !== (i < 2)) begin err_cnt++; $display("FAIL mid_rerun_div_clk cnt %0d: got %b want %b", i, div_clk, (i < 2)); end
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    enable           = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    test_reset();
    test_run_div4();
    test_cfg_apply();
    test_illegal();
    test_drain();
    test_coincident();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
